// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default geometry,
// reset/exception fetch targets, the no-op instruction and FSM encoding.
package instruction_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;
  localparam logic [31:0] INSTR_NOP      = 32'h0000_0000;
  localparam int unsigned PC_STEP        = 4;

  typedef enum logic {
    FSM_RUN   = 1'b0,
    FSM_FAULT = 1'b1
  } fsm_e;

endpackage

// File: rtl/instruction_fetch_unit_pc_sel.sv
// Fetch address selection: picks the address presented to instruction
// memory this cycle (redirect > replay > sequential) and computes the
// sequential request PC for the next cycle.
module instruction_fetch_unit_pc_sel
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  input  logic              advance,
  input  logic [ADDR_W-1:0] resp_pc,
  input  logic [ADDR_W-1:0] req_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] req_pc_next
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  // Memory address priority: redirect, then replay of the held bundle, then sequential
  always_comb begin
    imem_addr = req_pc;
    if (redirect) begin
      imem_addr = redirect_pc;
    end else if (stall) begin
      imem_addr = resp_pc;
    end
  end

  // Next request PC: restart past the redirect target, step on advance, else hold
  always_comb begin
    req_pc_next = req_pc;
    if (redirect) begin
      req_pc_next = redirect_pc + STEP;
    end else if (advance) begin
      req_pc_next = req_pc + STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues addresses to a synchronous-read
// instruction memory and hands instructions to decode over valid/ready.
// Back-pressure is handled by re-issuing the held address so the memory
// output stays stable. Optional build macro IFU_EXC_VECTOR_EN: when defined,
// an accepted fault bundle triggers an automatic redirect to EXC_VECTOR on
// the next cycle instead of parking until an external redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_dout,
  input  logic              imem_exception,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_exc
);

  fsm_e              fsm_q;
  fsm_e              fsm_d;
  logic [ADDR_W-1:0] req_pc_p0;
  logic [ADDR_W-1:0] req_pc_next;
  logic [ADDR_W-1:0] resp_pc_p1;
  logic              vld_p1;
  logic              run;
  logic              issue;
  logic              stall;
  logic              accept;
  logic              fault_accept;
  logic              advance;
  logic              redirect_any;
  logic [ADDR_W-1:0] redirect_target;

`ifdef IFU_EXC_VECTOR_EN
  logic exc_redir_q;

  // One-cycle self-redirect request raised after a fault bundle is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_redir_q <= 1'b0;
    end else begin
      exc_redir_q <= fault_accept;
    end
  end

  assign redirect_any = redirect_valid | exc_redir_q;
`else
  assign redirect_any = redirect_valid;
`endif

  // External redirect always outranks the internal exception redirect
  assign redirect_target = redirect_valid ? redirect_pc : EXC_VECTOR;

  assign stall        = out_valid & ~out_ready;
  assign accept       = out_valid & out_ready;
  assign fault_accept = accept & imem_exception;
  assign advance      = run & ~stall;

  // ---- stage p0: address selection and issue to memory ----
  instruction_fetch_unit_pc_sel #(
    .ADDR_W (ADDR_W)
  ) u_pc_sel (
    .redirect    (redirect_any),
    .redirect_pc (redirect_target),
    .stall       (stall),
    .advance     (advance),
    .resp_pc     (resp_pc_p1),
    .req_pc      (req_pc_p0),
    .imem_addr   (imem_addr),
    .req_pc_next (req_pc_next)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= FSM_RUN;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next state: park on an accepted fault, any redirect resumes fetching
  always_comb begin
    fsm_d = fsm_q;
    if (redirect_any) begin
      fsm_d = FSM_RUN;
    end else if (fault_accept) begin
`ifdef IFU_EXC_VECTOR_EN
      fsm_d = FSM_RUN;
`else
      fsm_d = FSM_FAULT;
`endif
    end
  end

  // FSM outputs: presentation gating and whether a new fetch is issued
  always_comb begin
    run       = (fsm_q == FSM_RUN);
    out_valid = vld_p1 & ~redirect_any & run;
    issue     = run | redirect_any;
  end

  // Request PC and in-flight response tracking; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_p0  <= RESET_PC;
      resp_pc_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      req_pc_p0  <= req_pc_next;
      resp_pc_p1 <= imem_addr;
      vld_p1     <= issue;
    end
  end

  // ---- stage p1: memory response presented to decode ----
  assign out_instr = imem_exception ? INSTR_NOP : imem_dout;
  assign out_exc   = imem_exception;
  assign out_pc    = resp_pc_p1;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: synchronous-read memory model, a
// bundle-stream reference model checked every cycle, and directed vectors
// with literal expectations.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout = 32'h0;
  logic        imem_exception = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_exc;

  int n_cmp  = 0;
  int n_fail = 0;

  instruction_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .imem_exception (imem_exception),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_exc        (out_exc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Synchronous-read memory: data and misalignment flag for the address sampled at posedge
  always @(posedge clk) begin
    imem_dout      <= mem_word(imem_addr);
    imem_exception <= (imem_addr[1:0] != 2'b00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the PC of the bundle decode should see next
  logic [31:0] m_pc     = RESET_PC;
  logic        m_valid  = 1'b0;
  logic        m_parked = 1'b0;

  initial begin
    logic exp_v;
    logic exp_e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        m_valid  = 1'b0;
        m_pc     = RESET_PC;
        m_parked = 1'b0;
      end else begin
        exp_v = m_valid & ~m_parked & ~redirect_valid;
        exp_e = (m_pc[1:0] != 2'b00);
        check("model_valid", {31'b0, out_valid}, {31'b0, exp_v});
        if (exp_v) begin
          check("model_pc", out_pc, m_pc);
          check("model_exc", {31'b0, out_exc}, {31'b0, exp_e});
          check("model_instr", out_instr, exp_e ? 32'h0 : mem_word(m_pc));
        end
        if (redirect_valid) begin
          m_pc     = redirect_pc;
          m_valid  = 1'b1;
          m_parked = 1'b0;
        end else if (m_parked) begin
          m_parked = 1'b1;
        end else if (!m_valid) begin
          m_valid = 1'b1;
        end else if (out_ready) begin
          if (exp_e) begin
`ifdef IFU_EXC_VECTOR_EN
            m_pc    = EXC_VECTOR;
            m_valid = 1'b0;
`else
            m_parked = 1'b1;
`endif
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #3;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[12] = '{
    '{1'b1, 1'b0, 32'h0},   '{1'b0, 1'b0, 32'h0},   '{1'b0, 1'b1, 32'h200},
    '{1'b1, 1'b0, 32'h0},   '{1'b0, 1'b0, 32'h0},   '{1'b1, 1'b0, 32'h0},
    '{1'b1, 1'b1, 32'h300}, '{1'b0, 1'b0, 32'h0},   '{1'b1, 1'b0, 32'h0},
    '{1'b1, 1'b1, 32'h1F6}, '{1'b1, 1'b0, 32'h0},   '{1'b1, 1'b1, 32'h400}
  };

  initial begin
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("reset_imem_addr", imem_addr, RESET_PC);

    // Release reset: first address issued, nothing presented yet
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    check("first_imem_addr", imem_addr, 32'h0);
    check("first_cycle_valid", {31'b0, out_valid}, 32'd0);

    tick(1'b1, 1'b0, 32'h0);
    check("seq_valid0", {31'b0, out_valid}, 32'd1);
    check("seq_pc0", out_pc, 32'h0);
    check("seq_addr4", imem_addr, 32'h4);
    tick(1'b1, 1'b0, 32'h0);
    check("seq_pc4", out_pc, 32'h4);

    // Back-pressure for three cycles at PC 8
    tick(1'b0, 1'b0, 32'h0);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_pc", out_pc, 32'h8);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check("stall_hold_instr", out_instr, mem_word(32'h8));
    tick(1'b1, 1'b0, 32'h0);
    check("stall_release_pc", out_pc, 32'h8);
    tick(1'b1, 1'b0, 32'h0);
    check("after_stall_pc", out_pc, 32'hC);

    // Redirect squashes the bundle presented in the same cycle
    tick(1'b1, 1'b1, 32'h40);
    check("redirect_squash", {31'b0, out_valid}, 32'd0);
    check("redirect_addr", imem_addr, 32'h40);
    tick(1'b1, 1'b0, 32'h0);
    check("redirect_pc40", out_pc, 32'h40);
    tick(1'b1, 1'b0, 32'h0);
    check("redirect_pc44", out_pc, 32'h44);

    // Misaligned redirect produces a fault bundle held under back-pressure
    tick(1'b1, 1'b1, 32'h42);
    tick(1'b0, 1'b0, 32'h0);
    check("fault_exc", {31'b0, out_exc}, 32'd1);
    check("fault_pc", out_pc, 32'h42);
    check("fault_instr", out_instr, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check("fault_hold_pc", out_pc, 32'h42);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("post_fault_valid", {31'b0, out_valid}, 32'd0);
    tick(1'b1, 1'b0, 32'h0);
`ifdef IFU_EXC_VECTOR_EN
    check("exc_vector_pc", out_pc, EXC_VECTOR);
`else
    check("parked_valid", {31'b0, out_valid}, 32'd0);
`endif
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h100);
    tick(1'b1, 1'b0, 32'h0);
    check("resume_pc", out_pc, 32'h100);

    // Mixed ready/redirect pattern, including redirect while stalled
    foreach (vecs[i]) begin
      tick(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
    end
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);

    // PC wraps modulo 2^32
    tick(1'b1, 1'b1, 32'hFFFF_FFFC);
    tick(1'b1, 1'b0, 32'h0);
    check("wrap_top_pc", out_pc, 32'hFFFF_FFFC);
    tick(1'b1, 1'b0, 32'h0);
    check("wrap_pc", out_pc, 32'h0);
    tick(1'b1, 1'b0, 32'h0);

    // Asynchronous reset between edges
    tick(1'b1, 1'b0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'b0, out_valid}, 32'd0);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    tick(1'b1, 1'b0, 32'h0);
    check("restart_pc", out_pc, RESET_PC);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("restart_pc8", out_pc, 32'h8);
    tick(1'b1, 1'b0, 32'h0);

    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
